// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the single-port SRAM requester arbiter.
// The round-robin wrap helper is used for both the free-running pointer and the lock-exit pointer.
package sram_port_arbiter_pkg;

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } ArbState;

    localparam int ARB_RD_LAT = 1;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side command/response bundle: packed per-requester command fields plus shared read data.
// The requester side drives commands (master); the arbiter answers with ack and read responses (slave).
interface sram_port_arbiter_if
    import sram_port_arbiter_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);

    logic [N_REQ-1:0]        req_rdy;
    logic [N_REQ-1:0]        req_ack;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ-1:0]        req_lock;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        rsp_dval;
    logic [DATA_W-1:0]       rsp_rdata;

    modport master (
        output req_rdy, req_we, req_lock, req_addr, req_wdata,
        input  req_ack, rsp_dval, rsp_rdata
    );

    modport slave (
        input  req_rdy, req_we, req_lock, req_addr, req_wdata,
        output req_ack, rsp_dval, rsp_rdata
    );

endinterface

// File: rtl/sram_port_arbiter_rr_pick.sv
// Combinational round-robin find-first: first set request at or after i_ptr, wrapping modulo N_REQ.
// The request vector is doubled so a single rotated window holds the search order.
module rr_priority_pick
    import sram_port_arbiter_pkg::*;
#(
    parameter int  N_REQ = 4,
    localparam int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic             o_gnt_vld,
    output logic [PTR_W-1:0] o_gnt_idx
);

    localparam logic [PTR_W:0] N_WIDE = (PTR_W+1)'(N_REQ);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [PTR_W:0]     w_sum;

    assign w_dbl = {i_req, i_req};
    assign w_rot = w_dbl[i_ptr +: N_REQ];

    // Scan from the far end so the nearest offset to i_ptr is the last one written.
    always_comb begin
        o_gnt_vld = 1'b0;
        o_gnt_idx = '0;
        w_sum     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
                if (w_sum >= N_WIDE) begin
                    w_sum = w_sum - N_WIDE;
                end
                o_gnt_vld = 1'b1;
                o_gnt_idx = w_sum[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM among N_REQ requesters: round-robin grant, bounded burst lock,
// and a one-cycle registered read-data strobe per requester.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    sram_port_arbiter_if.slave  bus,
    output logic                o_sram_ce,
    output logic                o_sram_we,
    output logic [ADDR_W-1:0]   o_sram_addr,
    output logic [DATA_W-1:0]   o_sram_wdata,
    input  logic [DATA_W-1:0]   i_sram_rdata
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    ArbState           r_state;
    ArbState           w_state_nxt;
    logic [PTR_W-1:0]  r_rr_ptr;
    logic [PTR_W-1:0]  w_rr_ptr_nxt;
    logic [PTR_W-1:0]  r_owner;
    logic [PTR_W-1:0]  w_owner_nxt;
    logic [CNT_W-1:0]  r_burst_cnt;
    logic [CNT_W-1:0]  w_burst_cnt_nxt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [N_REQ-1:0]  r_dval_p1;

    logic              w_pick_vld;
    logic [PTR_W-1:0]  w_pick_idx;
    logic              w_gnt_vld;
    logic [PTR_W-1:0]  w_gnt_idx;
    logic [N_REQ-1:0]  w_ack;
    logic [N_REQ-1:0]  w_rd_ack;

    // Only consulted while FREE; LOCKED grants come straight from the owner register.
    rr_priority_pick #(
        .N_REQ     (N_REQ)
    ) u_pick (
        .i_req     (bus.req_rdy),
        .i_ptr     (r_rr_ptr),
        .o_gnt_vld (w_pick_vld),
        .o_gnt_idx (w_pick_idx)
    );

    assign w_cnt_inc = r_burst_cnt + CNT_W'(1);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= ARB_FREE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_owner_nxt     = r_owner;
        w_burst_cnt_nxt = r_burst_cnt;
        w_gnt_vld       = 1'b0;
        w_gnt_idx       = r_owner;
        case (r_state)
            ARB_FREE: begin
                if (w_pick_vld) begin
                    w_gnt_vld    = 1'b1;
                    w_gnt_idx    = w_pick_idx;
                    w_rr_ptr_nxt = PTR_W'(rr_next(32'(w_pick_idx), N_REQ));
                    if (bus.req_lock[w_pick_idx] && (MAX_BURST > 1)) begin
                        w_state_nxt     = ARB_LOCKED;
                        w_owner_nxt     = w_pick_idx;
                        w_burst_cnt_nxt = CNT_W'(1);
                    end
                end
            end
            ARB_LOCKED: begin
                // Non-owners are shut out even when the owner idles with lock held.
                if (bus.req_rdy[r_owner]) begin
                    w_gnt_vld       = 1'b1;
                    w_gnt_idx       = r_owner;
                    w_burst_cnt_nxt = w_cnt_inc;
                    if (!bus.req_lock[r_owner] || (w_cnt_inc == MAX_CNT)) begin
                        w_state_nxt     = ARB_FREE;
                        w_rr_ptr_nxt    = PTR_W'(rr_next(32'(r_owner), N_REQ));
                        w_burst_cnt_nxt = '0;
                    end
                end else if (!bus.req_lock[r_owner]) begin
                    w_state_nxt     = ARB_FREE;
                    w_burst_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ARB_FREE;
            end
        endcase
    end

    // Control outputs are forced quiet for the whole time reset is held.
    assign w_ack        = (i_rstn && w_gnt_vld) ? (N_REQ'(1) << w_gnt_idx) : '0;
    assign w_rd_ack     = w_ack & ~bus.req_we;
    assign bus.req_ack  = w_ack;

    assign o_sram_ce    = i_rstn & w_gnt_vld;
    assign o_sram_we    = i_rstn & w_gnt_vld & bus.req_we[w_gnt_idx];
    assign o_sram_addr  = bus.req_addr[32'(w_gnt_idx) * ADDR_W +: ADDR_W];
    assign o_sram_wdata = bus.req_wdata[32'(w_gnt_idx) * DATA_W +: DATA_W];

    // Read response stage: strobe lines up with the SRAM's registered output.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_dval_p1 <= '0;
        end else begin
            r_dval_p1 <= w_rd_ack;
        end
    end

    assign bus.rsp_dval  = r_dval_p1;
    assign bus.rsp_rdata = i_sram_rdata;

    a_ack_onehot: assert property (@(posedge i_clk) disable iff (!i_rstn) $onehot0(w_ack));
    a_ack_rdy:    assert property (@(posedge i_clk) disable iff (!i_rstn) (w_ack & ~bus.req_rdy) == '0);
    a_dval_onehot: assert property (@(posedge i_clk) disable iff (!i_rstn) $onehot0(r_dval_p1));
    a_rd_lat: assert property (@(posedge i_clk) disable iff (!i_rstn)
                               |w_rd_ack |-> ##ARB_RD_LAT (r_dval_p1 != '0));

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a per-cycle behavioural model of grant order, lock bursts and
// read data, plus literal grant sequences for the arbitration scenarios.
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int MB = 4;

    logic          clk;
    logic          rstn;
    logic          sram_ce;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    sram_port_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_port_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .bus          (bus),
        .o_sram_ce    (sram_ce),
        .o_sram_we    (sram_we),
        .o_sram_addr  (sram_addr),
        .o_sram_wdata (sram_wdata),
        .i_sram_rdata (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // SRAM behaviour: commands latched mid-cycle, applied at the next rising edge.
    logic [DW-1:0] mem [1024];
    logic          l_ce, l_we;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = DW'(32'hA000 + i);
        sram_rdata = '0;
        forever begin
            @(posedge clk);
            if (l_ce) begin
                if (l_we) mem[l_addr] = l_wdata;
                else      sram_rdata <= mem[l_addr];
            end
        end
    end

    // Reference model state: what the spec says the arbiter must be holding.
    logic [DW-1:0] shadow [1024];
    initial for (int i = 0; i < 1024; i++) shadow[i] = DW'(32'hA000 + i);

    bit            m_locked;
    int            m_ptr, m_owner, m_cnt, m_g;
    logic [N-1:0]  m_pend;
    logic [DW-1:0] m_pend_data;
    logic [N-1:0]  m_eack;
    logic [AW-1:0] m_addr;
    logic [N-1:0]  ack_seen;

    int            act_log[$];
    int            ack_cyc_log[$];
    int            dval_idx_log[$];
    int            dval_cyc_log[$];
    logic [DW-1:0] dval_data_log[$];

    always @(negedge clk) begin
        cyc++;
        ack_seen = bus.req_ack;
        l_ce = sram_ce; l_we = sram_we; l_addr = sram_addr; l_wdata = sram_wdata;
        for (int i = 0; i < N; i++) begin
            if (bus.req_ack[i]) begin act_log.push_back(i); ack_cyc_log.push_back(cyc); end
            if (bus.rsp_dval[i]) begin
                dval_idx_log.push_back(i); dval_cyc_log.push_back(cyc);
                dval_data_log.push_back(bus.rsp_rdata);
            end
        end
        if (!rstn) begin
            chk("rst_ack", 32'(bus.req_ack), 0);
            chk("rst_ce", 32'(sram_ce), 0);
            chk("rst_we", 32'(sram_we), 0);
            chk("rst_dval", 32'(bus.rsp_dval), 0);
            m_locked = 0; m_ptr = 0; m_owner = 0; m_cnt = 0; m_pend = '0;
        end else begin
            chk("dval", 32'(bus.rsp_dval), 32'(m_pend));
            if (m_pend != '0) chk("rdata", 32'(bus.rsp_rdata), 32'(m_pend_data));
            m_g = -1;
            if (m_locked) begin
                if (bus.req_rdy[m_owner]) m_g = m_owner;
            end else begin
                for (int k = 0; k < N; k++)
                    if (m_g < 0 && bus.req_rdy[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
            end
            m_eack = '0;
            if (m_g >= 0) m_eack[m_g] = 1'b1;
            chk("ack", 32'(bus.req_ack), 32'(m_eack));
            chk("ce", 32'(sram_ce), (m_g >= 0) ? 1 : 0);
            m_pend = '0;
            if (m_g >= 0) begin
                m_addr = bus.req_addr[m_g*AW +: AW];
                chk("sram_we", 32'(sram_we), 32'(bus.req_we[m_g]));
                chk("sram_addr", 32'(sram_addr), 32'(m_addr));
                if (bus.req_we[m_g]) begin
                    chk("sram_wdata", 32'(sram_wdata), 32'(bus.req_wdata[m_g*DW +: DW]));
                    shadow[m_addr] = bus.req_wdata[m_g*DW +: DW];
                end else begin
                    m_pend[m_g] = 1'b1;
                    m_pend_data = shadow[m_addr];
                end
            end
            if (!m_locked) begin
                if (m_g >= 0) begin
                    m_ptr = (m_g + 1) % N;
                    if (bus.req_lock[m_g] && MB > 1) begin
                        m_locked = 1; m_owner = m_g; m_cnt = 1;
                    end
                end
            end else if (m_g >= 0) begin
                m_cnt++;
                if (!bus.req_lock[m_g] || m_cnt == MB) begin
                    m_locked = 0; m_ptr = (m_owner + 1) % N;
                end
            end else if (!bus.req_lock[m_owner]) begin
                m_locked = 0;
            end
        end
    end

    int left [N];

    task automatic set_req(input int i, input logic we, input logic lk, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int n);
        bus.req_we[i] = we;
        bus.req_lock[i] = lk;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_wdata[i*DW +: DW] = d;
        left[i] = n;
        bus.req_rdy[i] = (n > 0);
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++)
                if (ack_seen[i] && left[i] > 0) begin
                    left[i]--;
                    if (left[i] == 0) bus.req_rdy[i] = 1'b0;
                end
        end
    endtask

    task automatic clear_logs();
        act_log.delete(); ack_cyc_log.delete();
        dval_idx_log.delete(); dval_cyc_log.delete(); dval_data_log.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, '0, '0, 0);
        @(posedge clk); #1;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        clear_logs();
    endtask

    task automatic chk_seq(input string nm, input int exp_q[$]);
        chk({nm, "_len"}, act_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_log.size(); i++)
            chk(nm, act_log[i], exp_q[i]);
    endtask

    int  exp_q[$];
    bit  hit;

    initial begin
        rstn = 1'b0;
        bus.req_rdy = '0; bus.req_we = '0; bus.req_lock = '0;
        bus.req_addr = '0; bus.req_wdata = '0;
        l_ce = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;

        // Reset held with every requester asking.
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, AW'(i), '0, 1000);
        repeat (10) @(negedge clk);
        #1;
        chk("t1_acks_in_reset", act_log.size(), 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // All four reading continuously: plain rotation.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, AW'(i), '0, 1000);
        run_cycles(8);
        exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
        chk_seq("t2_order", exp_q);
        chk("t2_rdata0", (dval_data_log.size() > 0) ? 32'(dval_data_log[0]) : 32'hDEAD, 32'hA000);

        // Write @5 by req0 and read @5 by req2 in the same cycle.
        do_reset();
        set_req(0, 1'b1, 1'b0, 10'd5, 16'hBEEF, 1);
        set_req(2, 1'b0, 1'b0, 10'd5, 16'h0000, 1);
        run_cycles(4);
        exp_q = '{0, 2};
        chk_seq("t3_order", exp_q);
        chk("t3_ndval", dval_idx_log.size(), 1);
        if (dval_idx_log.size() == 1 && ack_cyc_log.size() == 2) begin
            chk("t3_dval_idx", dval_idx_log[0], 2);
            chk("t3_dval_lat", dval_cyc_log[0], ack_cyc_log[1] + 1);
            chk("t3_rdata", 32'(dval_data_log[0]), 32'hBEEF);
        end

        // Burst lock on req1 while the others wait.
        do_reset();
        set_req(1, 1'b0, 1'b1, 10'd1, '0, 1000);
        run_cycles(1);
        set_req(0, 1'b0, 1'b0, 10'd0, '0, 1000);
        set_req(2, 1'b0, 1'b0, 10'd2, '0, 1000);
        set_req(3, 1'b0, 1'b0, 10'd3, '0, 1000);
        run_cycles(6);
        exp_q = '{1, 1, 1, 1, 2, 3, 0};
        chk_seq("t4_burst", exp_q);

        // Reset lands between a read ack and its data strobe.
        do_reset();
        set_req(3, 1'b0, 1'b0, 10'd3, '0, 1);
        hit = 0;
        for (int t = 0; t < 5 && !hit; t++) begin
            @(negedge clk); #1;
            if (ack_seen[3]) hit = 1;
        end
        chk("t5_ack3_seen", 32'(hit), 1);
        rstn = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, AW'(i), '0, 1000);
        repeat (3) begin
            @(negedge clk); #1;
            chk("t5_dval_dropped", 32'(bus.rsp_dval), 0);
        end
        @(posedge clk); #1;
        clear_logs();
        rstn = 1'b1;
        run_cycles(1);
        exp_q = '{0};
        chk_seq("t5_first_after_rst", exp_q);

        // Lone requester 3: back-to-back grants through the pointer wrap.
        do_reset();
        set_req(3, 1'b0, 1'b0, 10'd7, '0, 5);
        run_cycles(8);
        exp_q = '{3, 3, 3, 3, 3};
        chk_seq("t6_solo", exp_q);
        chk("t6_ndval", dval_idx_log.size(), 5);
        if (dval_cyc_log.size() == 5) begin
            chk("t6_dval_span", dval_cyc_log[4] - dval_cyc_log[0], 4);
            chk("t6_dval_idx", dval_idx_log[4], 3);
            chk("t6_rdata", 32'(dval_data_log[4]), 32'hA007);
        end

        run_cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
